// File: rtl/soc_node_pkg.sv
// Shared definitions for the SoC node crossbar slice: AXI response codes
// and the state encodings used by the terminating error responder.
package soc_node_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of the AXI burst length field (beats minus one)
  localparam int unsigned AXI_LEN_WIDTH = 8;

  // Write-channel FSM of the error responder
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  // Read-channel FSM of the error responder
  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

endpackage : soc_node_pkg

// File: rtl/soc_node_decerr_slv.sv
// AXI4 terminating responder for unmapped crossbar ports. Every write burst
// is drained and answered with RESP on B; every read burst is answered with
// ar_len_i+1 beats of RDATA_PATTERN and RESP on R. One burst per direction
// is outstanding at a time, and the two directions run independently.
// err_pulse_o flags each accepted request one cycle after its handshake.
module soc_node_decerr_slv
  import soc_node_pkg::*;
#(
  parameter int unsigned                 AXI_ID_WIDTH   = 6,
  parameter int unsigned                 AXI_DATA_WIDTH = 64,
  parameter logic [1:0]                  RESP           = RESP_DECERR,
  parameter logic [AXI_DATA_WIDTH-1:0]   RDATA_PATTERN  = 'hBADCAB1E
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // write request
  input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  // write data (payload ignored)
  input  logic                      w_last_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  // write response
  output logic [AXI_ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]                b_resp_o,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  // read request
  input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
  input  logic [AXI_LEN_WIDTH-1:0]  ar_len_i,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  // read data
  output logic [AXI_ID_WIDTH-1:0]   r_id_o,
  output logic [AXI_DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  // event fabric
  output logic                      err_pulse_o
);

  wr_state_e                  wr_state, wr_next;
  rd_state_e                  rd_state, rd_next;
  logic [AXI_ID_WIDTH-1:0]    b_id_q;
  logic [AXI_ID_WIDTH-1:0]    r_id_q;
  logic [AXI_LEN_WIDTH-1:0]   rd_cnt_q;
  logic                       err_pulse_q;

  logic aw_hs, ar_hs, r_hs, rd_cnt_zero;

  // Handshakes are qualified by the state-decoded ready/valid outputs.
  assign aw_hs       = aw_valid_i & aw_ready_o;
  assign ar_hs       = ar_valid_i & ar_ready_o;
  assign r_hs        = r_valid_o & r_ready_i;
  assign rd_cnt_zero = (rd_cnt_q == '0);

  // Constant response fields
  assign b_resp_o = RESP;
  assign r_resp_o = RESP;
  assign r_data_o = RDATA_PATTERN;
  assign b_id_o   = b_id_q;
  assign r_id_o   = r_id_q;

  assign err_pulse_o = err_pulse_q;

  // Write FSM state register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state <= WR_IDLE;
    end else begin
      wr_state <= wr_next;
    end
  end

  // Write FSM next state and state-decoded handshake outputs
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wr_next    = wr_state;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) wr_next = WR_DATA;
      end
      WR_DATA: begin
        // W beats are accepted and dropped; only the last one matters
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) wr_next = WR_RESP;
      end
      WR_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) wr_next = WR_IDLE;
      end
      default: begin
        wr_next = WR_IDLE;
      end
    endcase
  end

  // Write response ID: captured on AW, held until the next AW
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_id_q <= '0;
    end else if (aw_hs) begin
      b_id_q <= aw_id_i;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  // Read FSM next state and state-decoded handshake outputs
  always_comb begin
    rd_next    = rd_state;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) rd_next = RD_DATA;
      end
      RD_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = rd_cnt_zero;
        if (r_ready_i && rd_cnt_zero) rd_next = RD_IDLE;
      end
      default: begin
        rd_next = RD_IDLE;
      end
    endcase
  end

  // Read ID capture and remaining-beat counter. The counter is loaded with
  // the burst length on AR and only decrements while non-zero, so a
  // 256-beat burst ends at zero instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_q   <= '0;
      rd_cnt_q <= '0;
    end else if (ar_hs) begin
      r_id_q   <= ar_id_i;
      rd_cnt_q <= ar_len_i;
    end else if (r_hs && !rd_cnt_zero) begin
      rd_cnt_q <= rd_cnt_q - 1'b1;
    end
  end

  // Event pulse: one cycle after any request handshake; simultaneous AW
  // and AR merge into a single pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= aw_hs | ar_hs;
    end
  end

endmodule : soc_node_decerr_slv

// File: tb/tb_soc_node_decerr_slv.sv
// Self-checking bench for soc_node_decerr_slv: table-driven read and write
// bursts, R/B scoreboards fed at request time and drained by a monitor,
// plus hand-written corner-case sequences.
module tb_soc_node_decerr_slv;

  localparam int unsigned IDW = 6;
  localparam int unsigned DW  = 64;
  localparam logic [DW-1:0] EXP_RDATA = 64'h0000_0000_BADC_AB1E;
  localparam logic [1:0]    EXP_RESP  = 2'b11;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [IDW-1:0]  aw_id_i;
  logic            aw_valid_i;
  logic            aw_ready_o;
  logic            w_last_i;
  logic            w_valid_i;
  logic            w_ready_o;
  logic [IDW-1:0]  b_id_o;
  logic [1:0]      b_resp_o;
  logic            b_valid_o;
  logic            b_ready_i;
  logic [IDW-1:0]  ar_id_i;
  logic [7:0]      ar_len_i;
  logic            ar_valid_i;
  logic            ar_ready_o;
  logic [IDW-1:0]  r_id_o;
  logic [DW-1:0]   r_data_o;
  logic [1:0]      r_resp_o;
  logic            r_last_o;
  logic            r_valid_o;
  logic            r_ready_i;
  logic            err_pulse_o;

  soc_node_decerr_slv #(
    .AXI_ID_WIDTH   (IDW),
    .AXI_DATA_WIDTH (DW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .aw_id_i     (aw_id_i),
    .aw_valid_i  (aw_valid_i),
    .aw_ready_o  (aw_ready_o),
    .w_last_i    (w_last_i),
    .w_valid_i   (w_valid_i),
    .w_ready_o   (w_ready_o),
    .b_id_o      (b_id_o),
    .b_resp_o    (b_resp_o),
    .b_valid_o   (b_valid_o),
    .b_ready_i   (b_ready_i),
    .ar_id_i     (ar_id_i),
    .ar_len_i    (ar_len_i),
    .ar_valid_i  (ar_valid_i),
    .ar_ready_o  (ar_ready_o),
    .r_id_o      (r_id_o),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .r_last_o    (r_last_o),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .err_pulse_o (err_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int r_beats  = 0;  // R handshakes seen by the monitor
  int b_beats  = 0;  // B handshakes seen by the monitor

  typedef struct {
    logic [IDW-1:0] id;
    logic           last;
  } r_exp_t;

  r_exp_t         r_q[$];
  logic [IDW-1:0] b_q[$];

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     len;
    int             exp_beats;
    logic           exp_last_first;
  } rd_vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    int             n_w;
    int             b_stall;
    logic [IDW-1:0] exp_bid;
  } wr_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one AR request (ar_ready_o is expected high), queue its beats.
  task automatic do_read_start(input logic [IDW-1:0] id, input logic [7:0] len);
    r_exp_t e;
    check("ar_ready_before_req", ar_ready_o, 1);
    ar_id_i    = id;
    ar_len_i   = len;
    ar_valid_i = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.last = (i == int'(len));
      r_q.push_back(e);
    end
    step();
    ar_valid_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Monitor: handshakes complete at the next rising edge, so sample on
  // the falling edge while inputs and outputs are stable.
  // ---------------------------------------------------------------------
  always @(negedge clk_i) begin
    r_exp_t  e;
    logic [IDW-1:0] bid;
    if (rst_ni && r_valid_o && r_ready_i) begin
      r_beats++;
      check("r_expected", (r_q.size() != 0), 1);
      if (r_q.size() != 0) begin
        e = r_q.pop_front();
        check("r_id",   r_id_o,   e.id);
        check("r_last", r_last_o, e.last);
        check("r_data", r_data_o, EXP_RDATA);
        check("r_resp", r_resp_o, EXP_RESP);
      end
    end
    if (rst_ni && b_valid_o && b_ready_i) begin
      b_beats++;
      check("b_expected", (b_q.size() != 0), 1);
      if (b_q.size() != 0) begin
        bid = b_q.pop_front();
        check("b_id",   b_id_o,   bid);
        check("b_resp", b_resp_o, EXP_RESP);
      end
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    rd_vec_t rd_tab[3];
    wr_vec_t wr_tab[3];
    int      snap;
    int      bad_ar;
    int      cyc;

    rd_tab[0] = '{id: 6'h2A, len: 8'd3, exp_beats: 4, exp_last_first: 1'b0};
    rd_tab[1] = '{id: 6'h11, len: 8'd0, exp_beats: 1, exp_last_first: 1'b1};
    rd_tab[2] = '{id: 6'h3F, len: 8'd7, exp_beats: 8, exp_last_first: 1'b0};

    wr_tab[0] = '{id: 6'h05, n_w: 2, b_stall: 5, exp_bid: 6'h05};
    wr_tab[1] = '{id: 6'h3A, n_w: 1, b_stall: 0, exp_bid: 6'h3A};
    wr_tab[2] = '{id: 6'h00, n_w: 4, b_stall: 2, exp_bid: 6'h00};

    rst_ni     = 1'b0;
    aw_id_i    = '0;
    aw_valid_i = 1'b0;
    w_last_i   = 1'b0;
    w_valid_i  = 1'b0;
    b_ready_i  = 1'b0;
    ar_id_i    = '0;
    ar_len_i   = '0;
    ar_valid_i = 1'b0;
    r_ready_i  = 1'b0;

    // --- reset values (held in reset) ---
    repeat (3) step();
    check("rst_aw_ready", aw_ready_o, 1);
    check("rst_ar_ready", ar_ready_o, 1);
    check("rst_b_valid",  b_valid_o,  0);
    check("rst_r_valid",  r_valid_o,  0);
    check("rst_r_last",   r_last_o,   0);
    check("rst_w_ready",  w_ready_o,  0);
    check("rst_err",      err_pulse_o, 0);
    check("rst_b_id",     b_id_o,     0);
    check("rst_r_id",     r_id_o,     0);

    // --- idle after release ---
    rst_ni = 1'b1;
    repeat (2) step();
    check("idle_aw_ready", aw_ready_o, 1);
    check("idle_ar_ready", ar_ready_o, 1);
    check("idle_b_valid",  b_valid_o,  0);
    check("idle_r_valid",  r_valid_o,  0);
    check("idle_err",      err_pulse_o, 0);

    // --- table-driven reads, r_ready_i held high ---
    r_ready_i = 1'b1;
    foreach (rd_tab[i]) begin
      snap = r_beats;
      do_read_start(rd_tab[i].id, rd_tab[i].len);
      check("rd_first_valid", r_valid_o,   1);
      check("rd_err_pulse",   err_pulse_o, 1);
      check("rd_first_last",  r_last_o,    rd_tab[i].exp_last_first);
      check("rd_ar_busy",     ar_ready_o,  0);
      repeat (int'(rd_tab[i].len) + 1) step();
      check("rd_beat_count",  r_beats - snap, rd_tab[i].exp_beats);
      check("rd_ar_ready_again", ar_ready_o, 1);
      check("rd_valid_done",  r_valid_o,   0);
      check("rd_err_done",    err_pulse_o, 0);
      check("rd_queue_empty", r_q.size(),  0);
    end
    r_ready_i = 1'b0;

    // --- table-driven writes with B back-pressure ---
    foreach (wr_tab[i]) begin
      snap = b_beats;
      check("wr_aw_ready_pre", aw_ready_o, 1);
      aw_id_i    = wr_tab[i].id;
      aw_valid_i = 1'b1;
      b_q.push_back(wr_tab[i].exp_bid);
      step();
      aw_valid_i = 1'b0;
      check("wr_w_ready",   w_ready_o,   1);
      check("wr_err_pulse", err_pulse_o, 1);
      check("wr_aw_busy",   aw_ready_o,  0);
      for (int k = 0; k < wr_tab[i].n_w; k++) begin
        check("wr_no_early_b", b_valid_o, 0);
        w_valid_i = 1'b1;
        w_last_i  = (k == wr_tab[i].n_w - 1);
        step();
      end
      w_valid_i = 1'b0;
      w_last_i  = 1'b0;
      check("wr_b_valid", b_valid_o, 1);
      check("wr_w_closed", w_ready_o, 0);
      check("wr_b_id",    b_id_o,    wr_tab[i].exp_bid);
      b_ready_i = 1'b0;
      for (int s = 0; s < wr_tab[i].b_stall; s++) begin
        step();
        check("wr_b_held",    b_valid_o, 1);
        check("wr_b_id_held", b_id_o,    wr_tab[i].exp_bid);
      end
      b_ready_i = 1'b1;
      step();
      b_ready_i = 1'b0;
      check("wr_b_count",       b_beats - snap, 1);
      check("wr_aw_ready_again", aw_ready_o, 1);
      check("wr_b_done",        b_valid_o,  0);
    end

    // --- W before AW stalls; simultaneous AW+AR give one pulse ---
    w_valid_i = 1'b1;
    w_last_i  = 1'b1;
    repeat (3) begin
      step();
      check("early_w_stalled", w_ready_o, 0);
    end
    aw_id_i    = 6'h12;
    aw_valid_i = 1'b1;
    b_q.push_back(6'h12);
    r_ready_i  = 1'b1;
    do_read_start(6'h21, 8'd0);
    aw_valid_i = 1'b0;
    check("dual_err_pulse", err_pulse_o, 1);
    check("dual_w_ready",   w_ready_o,   1);
    check("dual_r_valid",   r_valid_o,   1);
    step();
    check("dual_single_pulse", err_pulse_o, 0);
    check("dual_b_valid",      b_valid_o,   1);
    check("dual_r_done",       r_valid_o,   0);
    w_valid_i = 1'b0;
    w_last_i  = 1'b0;
    b_ready_i = 1'b1;
    step();
    b_ready_i = 1'b0;
    r_ready_i = 1'b0;
    check("dual_aw_ready", aw_ready_o, 1);
    check("dual_ar_ready", ar_ready_o, 1);
    check("dual_b_q_empty", b_q.size(), 0);
    check("dual_r_q_empty", r_q.size(), 0);

    // --- 256-beat read with random r_ready_i ---
    snap   = r_beats;
    bad_ar = 0;
    cyc    = 0;
    do_read_start(6'h33, 8'd255);
    while (r_q.size() != 0 && cyc < 4000) begin
      r_ready_i = 1'($urandom_range(0, 1));
      if (ar_ready_o) bad_ar++;
      step();
      cyc++;
    end
    r_ready_i = 1'b0;
    check("long_completed",     r_q.size(), 0);
    check("long_beat_count",    r_beats - snap, 256);
    check("long_ar_busy",       bad_ar, 0);
    check("long_ar_ready_after", ar_ready_o, 1);
    check("long_r_valid_after",  r_valid_o, 0);

    // --- reset in the middle of a read (and an open write) ---
    r_ready_i  = 1'b1;
    aw_id_i    = 6'h07;
    aw_valid_i = 1'b1;
    b_q.push_back(6'h07);
    do_read_start(6'h0C, 8'd3);
    aw_valid_i = 1'b0;
    step();  // beat 1 accepted; beat 2 now presented
    check("abort_beat2_valid", r_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("abort_r_valid",  r_valid_o,  0);
    check("abort_ar_ready", ar_ready_o, 1);
    check("abort_w_ready",  w_ready_o,  0);
    check("abort_aw_ready", aw_ready_o, 1);
    r_q.delete();
    b_q.delete();
    snap = r_beats + b_beats;
    repeat (2) step();
    rst_ni    = 1'b1;
    b_ready_i = 1'b1;
    w_valid_i = 1'b1;
    w_last_i  = 1'b1;
    repeat (10) step();
    check("post_rst_no_stray", r_beats + b_beats - snap, 0);
    check("post_rst_r_valid",  r_valid_o,   0);
    check("post_rst_b_valid",  b_valid_o,   0);
    check("post_rst_err",      err_pulse_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_soc_node_decerr_slv
